arrow_scheduler: RTL

Sequencer for the enemy-attack phase. On a start pulse it walks the selected turn's pattern table entry by entry, waits each entry's delay, then allocates a free slot from a fixed pool of arrow sprite instances and launches it with that entry's direction, speed and inversion. When the end marker is reached and every launched arrow has retired, it pulses finished. It sits between the game FSM (start/finished) and the arrow pool (per-slot launch strobes in, per-slot active flags out).

---
 rtl/arrow_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/arrow_scheduler.sv
// Enemy-attack sequencer: walks a turn's pattern table, waits each entry's delay,
// and launches arrows into free pool slots, pulsing finished once all arrows retire.
module arrow_scheduler #(
    parameter int N_SLOTS  = 8,
    parameter int TICK_DIV = 6500000,
    parameter int IDX_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_in,
    input  logic [3:0]           turn_in,
    output logic [IDX_W+3:0]     pat_addr_out,
    input  logic [7:0]           pat_data_in,
    input  logic [N_SLOTS-1:0]   slot_active_in,
    output logic [N_SLOTS-1:0]   spawn_out,
    output logic [1:0]           spawn_dir_out,
    output logic [1:0]           spawn_speed_out,
    output logic                 spawn_inv_out,
    output logic                 busy_out,
    output logic                 finished_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_DELAY = 3'd3,
        S_ALLOC = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [31:0]      TICK_W  = 32'(TICK_DIV);
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    state_t               state_r, state_s;
    logic [3:0]           turn_r, turn_s;
    logic [IDX_W-1:0]     index_r, index_s;
    logic [7:0]           entry_r, entry_s;
    logic [31:0]          cnt_r, cnt_s;
    logic [N_SLOTS-1:0]   pending_r, pending_s;
    logic [IDX_W+3:0]     pat_addr_r, pat_addr_s;
    logic [N_SLOTS-1:0]   spawn_r, spawn_s;
    logic [1:0]           dir_r, dir_s;
    logic [1:0]           speed_r, speed_s;
    logic                 inv_r, inv_s;
    logic                 busy_r, busy_s;
    logic                 finished_r, finished_s;

    logic [N_SLOTS-1:0]   free_s;
    logic [N_SLOTS-1:0]   pick_s;
    logic [31:0]          delay_total_s;
    logic                 alloc_try_s;

    assign pat_addr_out    = pat_addr_r;
    assign spawn_out       = spawn_r;
    assign spawn_dir_out   = dir_r;
    assign spawn_speed_out = speed_r;
    assign spawn_inv_out   = inv_r;
    assign busy_out        = busy_r;
    assign finished_out    = finished_r;

    // Lowest free slot isolated with the two's-complement trick.
    assign free_s        = ~(slot_active_in | pending_r);
    assign pick_s        = free_s & (~free_s + N_SLOTS'(1));
    assign delay_total_s = 32'(entry_r[2:0]) * TICK_W;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            turn_r     <= 4'd0;
            index_r    <= {IDX_W{1'b0}};
            entry_r    <= 8'd0;
            cnt_r      <= 32'd0;
            pending_r  <= {N_SLOTS{1'b0}};
            pat_addr_r <= {(IDX_W+4){1'b0}};
            spawn_r    <= {N_SLOTS{1'b0}};
            dir_r      <= 2'd0;
            speed_r    <= 2'd0;
            inv_r      <= 1'b0;
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            turn_r     <= turn_s;
            index_r    <= index_s;
            entry_r    <= entry_s;
            cnt_r      <= cnt_s;
            pending_r  <= pending_s;
            pat_addr_r <= pat_addr_s;
            spawn_r    <= spawn_s;
            dir_r      <= dir_s;
            speed_r    <= speed_s;
            inv_r      <= inv_s;
            busy_r     <= busy_s;
            finished_r <= finished_s;
        end
    end

    // Next-state logic. The slot decision is taken on the edge entering ALLOC (or
    // on each stalled ALLOC edge) so the registered strobe shows in ALLOC's first cycle.
    always_comb begin
        state_s     = state_r;
        turn_s      = turn_r;
        index_s     = index_r;
        entry_s     = entry_r;
        cnt_s       = cnt_r;
        pat_addr_s  = pat_addr_r;
        busy_s      = busy_r;
        finished_s  = 1'b0;
        spawn_s     = {N_SLOTS{1'b0}};
        dir_s       = 2'd0;
        speed_s     = 2'd0;
        inv_s       = 1'b0;
        pending_s   = pending_r & ~slot_active_in;
        alloc_try_s = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start_in) begin
                    turn_s     = turn_in;
                    index_s    = {IDX_W{1'b0}};
                    pat_addr_s = {turn_in, {IDX_W{1'b0}}};
                    busy_s     = 1'b1;
                    state_s    = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: state_s = S_LATCH;
            S_LATCH: begin
                entry_s = pat_data_in;
                if (pat_data_in[2:0] == 3'd0) begin
                    state_s = S_DRAIN;
                end else begin
                    cnt_s   = 32'd0;
                    state_s = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_r == delay_total_s - 32'd1) begin
                    alloc_try_s = 1'b1;
                    state_s     = S_ALLOC;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            S_ALLOC: begin
                if (spawn_r != {N_SLOTS{1'b0}}) begin
                    if (index_r == IDX_MAX) begin
                        state_s = S_DRAIN;
                    end else begin
                        index_s    = index_r + IDX_W'(1);
                        pat_addr_s = {turn_r, index_r + IDX_W'(1)};
                        state_s    = S_FETCH;
                    end
                end else begin
                    alloc_try_s = 1'b1;
                end
            end
            S_DRAIN: begin
                if ((slot_active_in == {N_SLOTS{1'b0}}) && (pending_r == {N_SLOTS{1'b0}})) begin
                    finished_s = 1'b1;
                    busy_s     = 1'b0;
                    state_s    = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase

        if (alloc_try_s && (pick_s != {N_SLOTS{1'b0}})) begin
            spawn_s   = pick_s;
            dir_s     = entry_r[4:3];
            speed_s   = entry_r[6:5];
            inv_s     = entry_r[7];
            pending_s = pending_s | pick_s;
        end else begin
            spawn_s = {N_SLOTS{1'b0}};
        end
    end

endmodule
